// File: rtl/cep_loop_if.sv
// Handshake and MAC-control bundle between the cepstral loop controller and its host.
interface cep_loop_if #(
    parameter int unsigned CEP_WIDTH  = 6,
    parameter int unsigned FILT_WIDTH = 6
);
    logic                  start;
    logic                  abort;
    logic [CEP_WIDTH-1:0]  num_cep;
    logic [FILT_WIDTH-1:0] num_filt;
    logic                  out_ready;
    logic                  busy;
    logic                  mac_clr;
    logic                  mac_en;
    logic                  mac_last;
    logic [CEP_WIDTH-1:0]  cep_idx;
    logic [FILT_WIDTH-1:0] filt_idx;
    logic                  res_valid;
    logic                  done;

    modport master (
        output start, abort, num_cep, num_filt, out_ready,
        input  busy, mac_clr, mac_en, mac_last, cep_idx, filt_idx, res_valid, done
    );

    modport slave (
        input  start, abort, num_cep, num_filt, out_ready,
        output busy, mac_clr, mac_en, mac_last, cep_idx, filt_idx, res_valid, done
    );
endinterface

// File: rtl/cep_loop_ctrl.sv
// Cepstral (DCT) loop sequencer: steps k over coefficients and m over filters,
// strobing the shared MAC, draining its pipeline and handing each result downstream.
module cep_loop_ctrl #(
    parameter int unsigned CEP_WIDTH  = 6,
    parameter int unsigned FILT_WIDTH = 6,
    parameter int unsigned MAC_LAT    = 2
) (
    input  logic      clk,
    input  logic      rst,
    cep_loop_if.slave bus
);
    localparam int unsigned DRAIN_W = 4;
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'((MAC_LAT == 0) ? 0 : MAC_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_ACCUM,
        S_DRAIN,
        S_OUTPUT,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [CEP_WIDTH-1:0]  ncep_q, ncep_d;
    logic [FILT_WIDTH-1:0] nfilt_q, nfilt_d;
    logic [CEP_WIDTH-1:0]  cep_q, cep_d;
    logic [FILT_WIDTH-1:0] filt_q, filt_d;
    logic [DRAIN_W-1:0]    drain_q, drain_d;
    logic                  busy_q, busy_d;
    logic                  mac_clr_q, mac_clr_d;
    logic                  mac_en_q, mac_en_d;
    logic                  mac_last_q, mac_last_d;
    logic                  res_valid_q, res_valid_d;
    logic                  done_q, done_d;

    // Next state, counters and the registered output image of the next state.
    always_comb begin
        state_d = state_q;
        ncep_d  = ncep_q;
        nfilt_d = nfilt_q;
        cep_d   = cep_q;
        filt_d  = filt_q;
        drain_d = drain_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.abort) begin
                    ncep_d  = bus.num_cep;
                    nfilt_d = bus.num_filt;
                    cep_d   = '0;
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: state_d = S_ACCUM;
            S_ACCUM: begin
                if (filt_q == nfilt_q) begin
                    drain_d = '0;
                    state_d = (MAC_LAT == 0) ? S_OUTPUT : S_DRAIN;
                end else begin
                    filt_d = filt_q + FILT_WIDTH'(1);
                end
            end
            S_DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    state_d = S_OUTPUT;
                end else begin
                    drain_d = drain_q + DRAIN_W'(1);
                end
            end
            S_OUTPUT: begin
                if (bus.out_ready) begin
                    if (cep_q == ncep_q) begin
                        state_d = S_DONE;
                    end else begin
                        cep_d   = cep_q + CEP_WIDTH'(1);
                        state_d = S_CLEAR;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Abort beats every other transition, including the output handshake.
        if (bus.abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
        end

        if (state_d == S_CLEAR) begin
            filt_d = '0;
        end
        if (state_d == S_IDLE) begin
            cep_d   = '0;
            filt_d  = '0;
            drain_d = '0;
        end

        busy_d      = (state_d != S_IDLE);
        mac_clr_d   = (state_d == S_CLEAR);
        mac_en_d    = (state_d == S_ACCUM);
        mac_last_d  = (state_d == S_ACCUM) && (filt_d == nfilt_d);
        res_valid_d = (state_d == S_OUTPUT);
        done_d      = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ncep_q      <= '0;
            nfilt_q     <= '0;
            cep_q       <= '0;
            filt_q      <= '0;
            drain_q     <= '0;
            busy_q      <= 1'b0;
            mac_clr_q   <= 1'b0;
            mac_en_q    <= 1'b0;
            mac_last_q  <= 1'b0;
            res_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ncep_q      <= ncep_d;
            nfilt_q     <= nfilt_d;
            cep_q       <= cep_d;
            filt_q      <= filt_d;
            drain_q     <= drain_d;
            busy_q      <= busy_d;
            mac_clr_q   <= mac_clr_d;
            mac_en_q    <= mac_en_d;
            mac_last_q  <= mac_last_d;
            res_valid_q <= res_valid_d;
            done_q      <= done_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.mac_clr   = mac_clr_q;
    assign bus.mac_en    = mac_en_q;
    assign bus.mac_last  = mac_last_q;
    assign bus.cep_idx   = cep_q;
    assign bus.filt_idx  = filt_q;
    assign bus.res_valid = res_valid_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_cep_loop_ctrl.sv
// Bench for cep_loop_ctrl: per-cycle expected traces built from the loop rules,
// applied to a MAC_LAT=2 and a MAC_LAT=0 instance.
module tb_cep_loop_ctrl;
    localparam int unsigned CW = 6;
    localparam int unsigned FW = 6;

    typedef struct packed {
        logic          busy;
        logic          clr;
        logic          en;
        logic          last;
        logic [CW-1:0] cep;
        logic [FW-1:0] filt;
        logic          valid;
        logic          done;
    } out_t;

    typedef struct {
        logic          start;
        logic          abort;
        logic          ready;
        logic [CW-1:0] nc_in;
        logic [FW-1:0] nf_in;
        out_t          exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    cep_loop_if #(.CEP_WIDTH(CW), .FILT_WIDTH(FW)) bus2 ();
    cep_loop_if #(.CEP_WIDTH(CW), .FILT_WIDTH(FW)) bus0 ();

    cep_loop_ctrl #(.CEP_WIDTH(CW), .FILT_WIDTH(FW), .MAC_LAT(2)) dut2 (
        .clk(clk), .rst(rst), .bus(bus2.slave));
    cep_loop_ctrl #(.CEP_WIDTH(CW), .FILT_WIDTH(FW), .MAC_LAT(0)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0.slave));

    vec_t vq[$];
    int   checks = 0;
    int   errors = 0;
    int   clr_cnt, en_cnt, last_cnt, done_cnt, done_delay;

    function automatic out_t mk(input bit clr, en, last, valid, done, input int cep, filt);
        out_t o;
        o.busy = 1'b1; o.clr = clr; o.en = en; o.last = last;
        o.cep = CW'(cep); o.filt = FW'(filt); o.valid = valid; o.done = done;
        return o;
    endfunction

    function automatic out_t rd(input int sel);
        out_t o;
        if (sel == 0) begin
            o.busy = bus2.busy; o.clr = bus2.mac_clr; o.en = bus2.mac_en; o.last = bus2.mac_last;
            o.cep = bus2.cep_idx; o.filt = bus2.filt_idx; o.valid = bus2.res_valid; o.done = bus2.done;
        end else begin
            o.busy = bus0.busy; o.clr = bus0.mac_clr; o.en = bus0.mac_en; o.last = bus0.mac_last;
            o.cep = bus0.cep_idx; o.filt = bus0.filt_idx; o.valid = bus0.res_valid; o.done = bus0.done;
        end
        return o;
    endfunction

    task automatic drive(input int sel, input logic st, ab, rdy, input logic [CW-1:0] nc, input logic [FW-1:0] nf);
        if (sel == 0) begin
            bus2.start = st; bus2.abort = ab; bus2.out_ready = rdy; bus2.num_cep = nc; bus2.num_filt = nf;
        end else begin
            bus0.start = st; bus0.abort = ab; bus0.out_ready = rdy; bus0.num_cep = nc; bus0.num_filt = nf;
        end
    endtask

    task automatic push(input logic st, ab, rdy, input int nc, nf, input out_t e);
        vec_t v;
        v.start = st; v.abort = ab; v.ready = rdy;
        v.nc_in = CW'(nc); v.nf_in = FW'(nf); v.exp = e;
        vq.push_back(v);
    endtask

    // Expected trace of one frame: IDLE+start, then per k: CLEAR, ACCUM m=0..nf, DRAIN, OUTPUT (+stalls); DONE; IDLE.
    task automatic add_frame(input int nc, nf, lat, smin, smax, input bit noisy);
        int s;
        push(1'b1, 1'b0, noisy ? 1'($urandom) : 1'b1, nc, nf, '0);
        for (int k = 0; k <= nc; k++) begin
            push(noisy ? 1'($urandom) : 1'b0, 1'b0, noisy ? 1'($urandom) : 1'b1,
                 int'($urandom), int'($urandom), mk(1, 0, 0, 0, 0, k, 0));
            for (int m = 0; m <= nf; m++)
                push(noisy ? 1'($urandom) : 1'b0, 1'b0, noisy ? 1'($urandom) : 1'b1,
                     int'($urandom), int'($urandom), mk(0, 1, m == nf, 0, 0, k, m));
            for (int d = 0; d < lat; d++)
                push(noisy ? 1'($urandom) : 1'b0, 1'b0, noisy ? 1'($urandom) : 1'b1,
                     int'($urandom), int'($urandom), mk(0, 0, 0, 0, 0, k, nf));
            s = int'($urandom_range(smax, smin));
            for (int i = 0; i < s; i++)
                push(noisy ? 1'($urandom) : 1'b0, 1'b0, 1'b0,
                     int'($urandom), int'($urandom), mk(0, 0, 0, 1, 0, k, nf));
            push(noisy ? 1'($urandom) : 1'b0, 1'b0, 1'b1,
                 int'($urandom), int'($urandom), mk(0, 0, 0, 1, 0, k, nf));
        end
        push(noisy ? 1'($urandom) : 1'b0, 1'b0, 1'b1, int'($urandom), int'($urandom), mk(0, 0, 0, 0, 1, nc, nf));
        push(1'b0, noisy ? 1'($urandom) : 1'b0, 1'b1, 0, 0, '0);
    endtask

    // Abort at vector idx: drop the rest of the frame, expect IDLE with all outputs low next cycle.
    task automatic abort_at(input int idx);
        vq[idx].abort = 1'b1;
        while (vq.size() > idx + 1) void'(vq.pop_back());
        push(1'b0, 1'b0, 1'b1, 0, 0, '0);
    endtask

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    task automatic run(input int sel, input string name);
        int first_clr = -1;
        int done_at = -1;
        out_t got;
        clr_cnt = 0; en_cnt = 0; last_cnt = 0; done_cnt = 0;
        for (int i = 0; i < vq.size(); i++) begin
            @(posedge clk); #1;
            got = rd(sel);
            checks++;
            if (got !== vq[i].exp) begin
                errors++;
                $display("FAIL %s cycle %0d: got %h, want %h", name, i, got, vq[i].exp);
            end
            if (got.clr) begin
                clr_cnt++;
                if (first_clr < 0) first_clr = i;
            end
            if (got.en) en_cnt++;
            if (got.last) last_cnt++;
            if (got.done) begin
                done_cnt++;
                if (done_at < 0) done_at = i;
            end
            drive(sel, vq[i].start, vq[i].abort, vq[i].ready, vq[i].nc_in, vq[i].nf_in);
        end
        done_delay = (first_clr >= 0 && done_at >= 0) ? done_at - first_clr : -1;
        vq.delete();
    endtask

    initial begin
        int base, idx, nc, nf, sel, lat;
        bit hit;
        drive(0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        #1 rst = 1'b1;
        #2;
        check("reset_out_dut2", int'(rd(0)), 0);
        check("reset_out_dut0", int'(rd(1)), 0);
        @(negedge clk) rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 check("idle_after_reset", int'(rd(0)), 0);

        // Nominal frame.
        add_frame(12, 25, 2, 0, 0, 1'b0);
        run(0, "nominal");
        check("nominal_clr_pulses", clr_cnt, 13);
        check("nominal_en_cycles", en_cnt, 13 * 26);
        check("nominal_last", last_cnt, 13);
        check("nominal_done_delay", done_delay, 13 * (25 + 2 + 3));

        // Backpressure: 5 stall cycles at every OUTPUT.
        add_frame(12, 25, 2, 5, 5, 1'b0);
        run(0, "backpressure");
        check("bp_done_delay", done_delay, 13 * (25 + 2 + 3) + 13 * 5);

        // Minimum sizes with no drain.
        add_frame(0, 0, 0, 0, 0, 1'b0);
        run(1, "minimum");
        check("min_done_delay", done_delay, 3);
        check("min_en_last", en_cnt * 10 + last_cnt, 11);

        // start together with abort in IDLE is ignored, as is a lone abort.
        push(1'b1, 1'b1, 1'b1, 3, 3, '0);
        push(1'b0, 1'b1, 1'b1, 3, 3, '0);
        push(1'b0, 1'b0, 1'b1, 0, 0, '0);
        run(0, "idle_start_abort");

        // Abort in ACCUM at k=4, m=10, then a clean frame.
        base = vq.size();
        add_frame(12, 25, 2, 0, 0, 1'b1);
        idx = -1;
        for (int i = base; i < vq.size(); i++)
            if (idx < 0 && vq[i].exp.en && vq[i].exp.cep == CW'(4) && vq[i].exp.filt == FW'(10)) idx = i;
        abort_at(idx);
        add_frame(3, 4, 2, 0, 0, 1'b0);
        run(0, "abort_accum");
        check("abort_accum_done_count", done_cnt, 1);

        // Abort colliding with the OUTPUT handshake.
        base = vq.size();
        add_frame(2, 3, 2, 1, 1, 1'b1);
        idx = -1;
        for (int i = base; i < vq.size(); i++)
            if (idx < 0 && vq[i].exp.valid && vq[i].ready && vq[i].exp.cep == CW'(1)) idx = i;
        abort_at(idx);
        add_frame(1, 2, 2, 0, 2, 1'b1);
        run(0, "abort_output");
        check("abort_output_done_count", done_cnt, 1);

        // All-ones boundaries.
        add_frame(63, 0, 0, 0, 1, 1'b1);
        run(1, "max_cep");
        add_frame(1, 63, 2, 0, 1, 1'b1);
        run(0, "max_filt");

        // Randomized frames with noisy inputs, random stalls and occasional aborts.
        for (int r = 0; r < 16; r++) begin
            sel = int'($urandom_range(1, 0));
            lat = (sel == 0) ? 2 : 0;
            nc = int'($urandom_range(5, 0));
            nf = int'($urandom_range(9, 0));
            base = vq.size();
            add_frame(nc, nf, lat, 0, 3, 1'b1);
            if ($urandom_range(2, 0) == 0)
                abort_at(base + int'($urandom_range(vq.size() - base - 2, 1)));
            run(sel, "random");
        end

        // Async reset between clock edges while in DRAIN.
        @(posedge clk); #1;
        drive(0, 1, 0, 1, 2, 3);
        @(posedge clk); #1;
        drive(0, 0, 0, 1, 0, 0);
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            @(posedge clk); #1;
            hit = bus2.mac_last;
        end
        check("reach_mac_last", int'(hit), 1);
        @(posedge clk); #1;
        check("in_drain", int'({bus2.busy, bus2.mac_en, bus2.res_valid}), 4);
        #2 rst = 1'b1;
        #1 check("async_reset_out", int'(rd(0)), 0);
        @(negedge clk) rst = 1'b0;
        repeat (4) @(posedge clk);
        #1 check("idle_after_async_reset", int'(rd(0)), 0);
        add_frame(1, 2, 2, 0, 1, 1'b0);
        run(0, "after_reset");
        check("after_reset_done_count", done_cnt, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
